// File: rtl/gray_window_3x3_pkg.sv
// -----------------------------------------------------------------------------
// gray_window_3x3_pkg
// Shared constants and types for the 3x3 gray-scale window generator.
//   CNN_*            : default image geometry and pixel width
//   state_e          : window generator FSM encoding
//   win_idx()        : element index of (row, col) inside the packed window
// -----------------------------------------------------------------------------
package gray_window_3x3_pkg;

    localparam int CNN_DATA_IN_W          = 8;
    localparam int CNN_IMG_IN_WIDTH       = 28;
    localparam int CNN_IMG_IN_HEIGHT      = 28;
    localparam int CNN_GRAY_BUFFER_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Row 0 is the oldest row, col 0 the oldest column.
    function automatic int win_idx(input int row, input int col);
        return 3 * row + col;
    endfunction

endpackage

// File: rtl/gray_window_3x3_linebuf.sv
// -----------------------------------------------------------------------------
// graylinebuffer
// Simple dual-port line memory with a registered read port. A read and a
// write to the same address on the same edge returns the old contents.
//   clkw, w_en, w_addr, w_data : write port
//   clkr, r_en, r_addr         : read request
//   r_data                     : read data, valid the cycle after r_en
// Memory contents are intentionally not reset.
// -----------------------------------------------------------------------------
module graylinebuffer #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clkw,
    input  logic          w_en,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          clkr,
    input  logic          r_en,
    input  logic [AW-1:0] r_addr,
    output logic [DW-1:0] r_data
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clkw) begin
        if (w_en) begin
            mem_q[w_addr] <= w_data;
        end
    end

    // Registered read port; holds its value while r_en is low.
    always_ff @(posedge clkr) begin
        if (r_en) begin
            r_data <= mem_q[r_addr];
        end
    end

endmodule

// File: rtl/gray_window_3x3.sv
// -----------------------------------------------------------------------------
// gray_window_3x3
// Builds a sliding 3x3 window over a raster-scanned gray image using two line
// buffers (previous row, row before that) and a 3x3 shift register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/in_sof : pixel valid, start-of-frame (row 0, col 0)
//   in_data         : gray pixel
//   in_ready        : low only for the single flush cycle after a frame ends
//   win_valid       : win_data holds a complete window (2-cycle latency)
//   win_data        : element k = 3*row+col at bits [k*DW +: DW]
//   frame_done      : pulses with the last window of a frame
// -----------------------------------------------------------------------------
module gray_window_3x3
    import gray_window_3x3_pkg::*;
#(
    parameter int DW    = CNN_DATA_IN_W,
    parameter int IMG_W = CNN_IMG_IN_WIDTH,
    parameter int IMG_H = CNN_IMG_IN_HEIGHT,
    parameter int AW    = CNN_GRAY_BUFFER_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_sof,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            win_valid,
    output logic [9*DW-1:0] win_data,
    output logic            frame_done
);

    localparam int            RW       = 16;
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e        state_q;
    logic [AW-1:0] col_q, col_d, c_cur_s;
    logic [RW-1:0] row_q, row_d, r_cur_s;
    logic          accept_s, take_s, last_s;

    logic [DW-1:0] lb0_rd_s, lb1_rd_s;
    logic [DW-1:0] pix_q;
    logic [AW-1:0] c_q;
    logic [RW-1:0] r_q;
    logic          acc_q, last_q;
    logic [9*DW-1:0] win_q;
    logic          win_valid_q, frame_done_q;
    logic [2:0][DW-1:0] new_col_s;

    assign in_ready = (state_q != ST_FLUSH);

    // Position of the incoming pixel and the scan position that follows it.
    always_comb begin
        accept_s = in_valid && in_ready;
        // Pixels without in_sof are only meaningful once a frame is running.
        take_s   = accept_s && (in_sof || (state_q == ST_RUN));
        if (in_sof) begin
            c_cur_s = '0;
            r_cur_s = '0;
        end else begin
            c_cur_s = col_q;
            r_cur_s = row_q;
        end
        last_s = (c_cur_s == COL_LAST) && (r_cur_s == ROW_LAST);
        if (last_s) begin
            col_d = '0;
            row_d = '0;
        end else if (c_cur_s == COL_LAST) begin
            col_d = '0;
            row_d = r_cur_s + RW'(1);
        end else begin
            col_d = c_cur_s + AW'(1);
            row_d = r_cur_s;
        end
    end

    // Frame FSM with scan position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (take_s) begin
                        col_q   <= col_d;
                        row_q   <= row_d;
                        state_q <= last_s ? ST_FLUSH : ST_RUN;
                    end else begin
                        col_q   <= col_q;
                        row_q   <= row_q;
                        state_q <= state_q;
                    end
                end
                ST_FLUSH: begin
                    col_q   <= '0;
                    row_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    col_q   <= '0;
                    row_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    graylinebuffer #(.DW(DW), .AW(AW), .DEPTH(IMG_W)) u_lb0 (
        .clkw   (clk),
        .w_en   (take_s),
        .w_addr (c_cur_s),
        .w_data (in_data),
        .clkr   (clk),
        .r_en   (take_s),
        .r_addr (c_cur_s),
        .r_data (lb0_rd_s)
    );

    // Buffer 1 is fed from buffer 0's read data one cycle later, so it ends
    // up holding the row two above the current one.
    graylinebuffer #(.DW(DW), .AW(AW), .DEPTH(IMG_W)) u_lb1 (
        .clkw   (clk),
        .w_en   (acc_q),
        .w_addr (c_q),
        .w_data (lb0_rd_s),
        .clkr   (clk),
        .r_en   (take_s),
        .r_addr (c_cur_s),
        .r_data (lb1_rd_s)
    );

    // New rightmost column, top (oldest row) to bottom.
    assign new_col_s = {pix_q, lb0_rd_s, lb1_rd_s};

    // Two-stage window pipeline: capture the pixel, then shift in its column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q        <= '0;
            c_q          <= '0;
            r_q          <= '0;
            acc_q        <= 1'b0;
            last_q       <= 1'b0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            acc_q <= take_s;
            if (take_s) begin
                pix_q  <= in_data;
                c_q    <= c_cur_s;
                r_q    <= r_cur_s;
                last_q <= last_s;
            end else begin
                pix_q  <= pix_q;
                c_q    <= c_q;
                r_q    <= r_q;
                last_q <= last_q;
            end
            if (acc_q) begin
                for (int row = 0; row < 3; row++) begin
                    win_q[win_idx(row, 0)*DW +: DW] <= win_q[win_idx(row, 1)*DW +: DW];
                    win_q[win_idx(row, 1)*DW +: DW] <= win_q[win_idx(row, 2)*DW +: DW];
                    win_q[win_idx(row, 2)*DW +: DW] <= new_col_s[row];
                end
                // Columns 0/1 are stale when c < 2, so only flag full windows.
                win_valid_q  <= (r_q >= RW'(2)) && (c_q >= AW'(2));
                frame_done_q <= last_q;
            end else begin
                win_q        <= win_q;
                win_valid_q  <= 1'b0;
                frame_done_q <= 1'b0;
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
module tb_gray_window_3x3;

    localparam int DW = 8;
    localparam int IW = 5;
    localparam int IH = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          win_valid;
    logic [9*DW-1:0] win_data;
    logic          frame_done;

    gray_window_3x3 #(.DW(DW), .IMG_W(IW), .IMG_H(IH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [71:0] data;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int win_cnt = 0;
    int fd_cnt = 0;
    int stall_cnt = 0;
    logic [71:0] first_win = '0;
    logic [71:0] last_win = '0;
    bit cap_first = 1'b0;

    // reference model state
    logic [7:0] img [IH][IW];
    int m_r = 0;
    int m_c = 0;
    bit m_run = 1'b0;
    bit m_flush = 1'b0;

    function automatic logic [71:0] pack_win(input int br, input int bc, input int off);
        logic [71:0] w = '0;
        for (int row = 0; row < 3; row++)
            for (int col = 0; col < 3; col++)
                w[(3*row+col)*8 +: 8] = 8'(10*(br+row) + bc + col + off);
        return w;
    endfunction

    // Advance the reference model by one clock edge.
    task automatic model_edge(input bit acc, input logic [7:0] d, input bit sof);
        int r;
        int c;
        bit last;
        exp_t e;
        if (m_flush) begin
            m_flush = 1'b0;
            m_run = 1'b0;
        end
        if (acc && (sof || m_run)) begin
            if (sof) begin r = 0; c = 0; end
            else begin r = m_r; c = m_c; end
            img[r][c] = d;
            last = (r == IH-1) && (c == IW-1);
            if (r >= 2 && c >= 2) begin
                e.data = '0;
                for (int row = 0; row < 3; row++)
                    for (int col = 0; col < 3; col++)
                        e.data[(3*row+col)*8 +: 8] = img[r-2+row][c-2+col];
                e.fd = last;
                e.cyc = cyc + 1;
                q.push_back(e);
            end
            if (last) begin
                m_flush = 1'b1; m_run = 1'b0; m_r = 0; m_c = 0;
            end else begin
                m_run = 1'b1;
                if (c == IW-1) begin m_c = 0; m_r = r + 1; end
                else begin m_c = c + 1; m_r = r; end
            end
        end
    endtask

    // Present one beat; called #1 after a rising edge, returns #1 after the edge that took it.
    task automatic drive(input logic [7:0] d, input bit sof, input bit v);
        logic rdy;
        int waitc = 0;
        in_data = d;
        in_sof = sof;
        in_valid = v;
        forever begin
            rdy = in_ready;
            n_checks++;
            if (rdy !== !m_flush) begin
                n_fail++;
                $display("FAIL in_ready: got %b expected %b at cycle %0d", rdy, !m_flush, cyc);
            end
            if (v && !rdy) stall_cnt++;
            @(posedge clk);
            #1;
            model_edge(v && rdy, d, sof);
            if (!v || rdy) break;
            waitc++;
            if (waitc > 20) begin
                n_checks++; n_fail++;
                $display("FAIL ready_timeout: in_ready stuck at 0 for %0d cycles, expected 1", waitc);
                break;
            end
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'd0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int off, input bit gap);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                drive(8'(off + 10*r + c), (r == 0) && (c == 0), 1'b1);
                if (gap) drive(8'd0, 1'b0, 1'b0);
            end
    endtask

    // Scoreboard: compare every DUT window against the expected queue.
    always @(negedge clk) begin
        if (rst_n && (win_valid || frame_done)) begin
            if (win_valid) win_cnt++;
            if (frame_done) fd_cnt++;
            if (q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_output: win_valid=%b frame_done=%b data=%h, expected no output", win_valid, frame_done, win_data);
            end else begin
                mon_e = q.pop_front();
                n_checks++;
                if (win_valid !== 1'b1) begin
                    n_fail++; $display("FAIL win_valid: got %b expected 1", win_valid);
                end
                n_checks++;
                if (win_data !== mon_e.data) begin
                    n_fail++; $display("FAIL win_data: got %h expected %h", win_data, mon_e.data);
                end
                n_checks++;
                if (frame_done !== mon_e.fd) begin
                    n_fail++; $display("FAIL frame_done: got %b expected %b", frame_done, mon_e.fd);
                end
                n_checks++;
                if (cyc !== mon_e.cyc) begin
                    n_fail++; $display("FAIL latency: window at cycle %0d expected cycle %0d", cyc, mon_e.cyc);
                end
            end
            if (win_valid) begin
                last_win = win_data;
                if (cap_first) begin first_win = win_data; cap_first = 1'b0; end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_win_valid: got %b expected 0", win_valid); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        n_checks++;
        if (win_data !== 72'h0) begin n_fail++; $display("FAIL rst_win_data: got %h expected 0", win_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int w0 = win_cnt;
        int f0 = fd_cnt;
        cap_first = 1'b1;
        send_frame(0, 1'b0);
        idle(4);
        n_checks++;
        if (win_cnt - w0 != 9) begin n_fail++; $display("FAIL basic_count: got %0d windows expected 9", win_cnt - w0); end
        n_checks++;
        if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL basic_frame_done: got %0d pulses expected 1", fd_cnt - f0); end
        n_checks++;
        if (first_win !== pack_win(0, 0, 0)) begin n_fail++; $display("FAIL basic_first: got %h expected %h", first_win, pack_win(0, 0, 0)); end
        n_checks++;
        if (last_win !== pack_win(2, 2, 0)) begin n_fail++; $display("FAIL basic_last: got %h expected %h", last_win, pack_win(2, 2, 0)); end
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL basic_pending: %0d windows missing expected 0", q.size()); end
    endtask

    task automatic test_toggle();
        int w0 = win_cnt;
        int f0 = fd_cnt;
        send_frame(0, 1'b1);
        idle(4);
        n_checks++;
        if (win_cnt - w0 != 9) begin n_fail++; $display("FAIL toggle_count: got %0d windows expected 9", win_cnt - w0); end
        n_checks++;
        if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL toggle_frame_done: got %0d pulses expected 1", fd_cnt - f0); end
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL toggle_pending: %0d windows missing expected 0", q.size()); end
    endtask

    task automatic test_junk();
        int w0 = win_cnt;
        for (int i = 0; i < 10; i++) drive(8'(200 + i), 1'b0, 1'b1);
        send_frame(0, 1'b0);
        idle(4);
        n_checks++;
        if (win_cnt - w0 != 9) begin n_fail++; $display("FAIL junk_count: got %0d windows expected 9", win_cnt - w0); end
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL junk_pending: %0d windows missing expected 0", q.size()); end
    endtask

    task automatic test_restart();
        int w0 = win_cnt;
        int f0 = fd_cnt;
        // frame A up to (3,1); the (3,2) pixel carries in_sof and starts frame B
        for (int i = 0; i < 17; i++) drive(8'(10*(i/5) + (i%5)), i == 0, 1'b1);
        send_frame(100, 1'b0);
        idle(4);
        n_checks++;
        if (win_cnt - w0 != 12) begin n_fail++; $display("FAIL restart_count: got %0d windows expected 12", win_cnt - w0); end
        n_checks++;
        if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL restart_frame_done: got %0d pulses expected 1", fd_cnt - f0); end
        n_checks++;
        if (last_win !== pack_win(2, 2, 100)) begin n_fail++; $display("FAIL restart_last: got %h expected %h", last_win, pack_win(2, 2, 100)); end
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL restart_pending: %0d windows missing expected 0", q.size()); end
    endtask

    task automatic test_reset_mid();
        int w0;
        int f0;
        for (int i = 0; i < 19; i++) drive(8'(10*(i/5) + (i%5)), i == 0, 1'b1);
        rst_n = 1'b0;
        q.delete();
        m_run = 1'b0; m_flush = 1'b0; m_r = 0; m_c = 0;
        #2;
        n_checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== 72'h0) begin
            n_fail++; $display("FAIL midrst_outputs: valid=%b done=%b data=%h expected all 0", win_valid, frame_done, win_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (win_valid !== 1'b0 || win_data !== 72'h0) begin
            n_fail++; $display("FAIL midrst_hold: valid=%b data=%h expected all 0", win_valid, win_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        w0 = win_cnt;
        f0 = fd_cnt;
        send_frame(0, 1'b0);
        idle(4);
        n_checks++;
        if (win_cnt - w0 != 9) begin n_fail++; $display("FAIL midrst_count: got %0d windows expected 9", win_cnt - w0); end
        n_checks++;
        if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL midrst_frame_done: got %0d pulses expected 1", fd_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int w0 = win_cnt;
        int f0 = fd_cnt;
        int s0 = stall_cnt;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        idle(4);
        n_checks++;
        if (win_cnt - w0 != 18) begin n_fail++; $display("FAIL b2b_count: got %0d windows expected 18", win_cnt - w0); end
        n_checks++;
        if (fd_cnt - f0 != 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses expected 2", fd_cnt - f0); end
        n_checks++;
        if (stall_cnt - s0 != 1) begin n_fail++; $display("FAIL b2b_stall: got %0d stall cycles expected 1", stall_cnt - s0); end
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL b2b_pending: %0d windows missing expected 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_junk();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
